// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// The state enum, default watchdog limit and watchdog counter width live here.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2
    } arb_state_e;

    localparam int UART_ARB_TIMEOUT_DEFAULT = 524288;
    localparam int UART_ARB_WD_W            = 20;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bus between byte producers, the arbiter and the shared uart_tx.
// slave: the arbiter's view; master: the producer/transmitter side.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0][7:0]    req_data;
    logic [NUM_REQ-1:0]         req_ready;
    logic                       cts_n;
    logic                       tx_done;
    logic [7:0]                 tx_data;
    logic                       start_tx;
    logic [$clog2(NUM_REQ)-1:0] grant_id;
    logic                       busy;
    logic                       timeout_err;

    modport slave (
        input  req_valid, req_data, cts_n, tx_done,
        output req_ready, tx_data, start_tx, grant_id, busy, timeout_err
    );

    modport master (
        output req_valid, req_data, cts_n, tx_done,
        input  req_ready, tx_data, start_tx, grant_id, busy, timeout_err
    );
endinterface

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request searching upward
// from i_last+1, wrapping modulo NUM_REQ. Output grant is one-hot.
module uart_rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_last,
    output logic [NUM_REQ-1:0]         o_gnt,
    output logic                       o_found
);
    localparam int GW = $clog2(NUM_REQ);

    int              w_idx;
    logic [GW-1:0]   w_sel;

    // Scan offsets 1..NUM_REQ so the previous winner is considered last.
    always_comb begin
        o_gnt   = '0;
        o_found = 1'b0;
        w_idx   = 0;
        w_sel   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = int'(i_last) + k;
            if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
            w_sel = GW'(w_idx);
            if (!o_found && i_req[w_sel]) begin
                o_gnt[w_sel] = 1'b1;
                o_found      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one uart_tx among NUM_REQ producers.
// Optional watchdog on WAIT_DONE enabled by defining UART_TX_ARB_WATCHDOG_EN.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = UART_ARB_TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_tx_arbiter_if.slave  bus
);
    localparam int GW = $clog2(NUM_REQ);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_START = START;
    localparam logic [1:0] S_WAIT  = WAIT_DONE;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2 ||
        TIMEOUT_CYCLES > (1 << UART_ARB_WD_W)) begin : g_bad_param
        $error("uart_tx_arbiter: NUM_REQ or TIMEOUT_CYCLES out of range");
    end

    logic [1:0]         r_state;
    logic [7:0]         r_tx_data;
    logic               r_start;
    logic [GW-1:0]      r_grant;
    logic [GW-1:0]      r_last;
    logic               r_busy;
    logic               r_tmo;

    logic [NUM_REQ-1:0] w_gnt;
    logic               w_found;
    logic               w_take;
    logic               w_timeout;
    logic [GW-1:0]      w_pick;
    logic [7:0]         w_pick_data;

    uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .i_req   (bus.req_valid),
        .i_last  (r_last),
        .o_gnt   (w_gnt),
        .o_found (w_found)
    );

    // Encode the one-hot winner and mux its byte.
    always_comb begin
        w_pick      = '0;
        w_pick_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_pick      = GW'(i);
                w_pick_data = w_pick_data | bus.req_data[i];
            end
        end
    end

    // Accept only from IDLE with CTS asserted; held off entirely in reset.
    assign w_take        = (r_state == S_IDLE) && !bus.cts_n && w_found;
    assign bus.req_ready = (rst_n && w_take) ? w_gnt : '0;

`ifdef UART_TX_ARB_WATCHDOG_EN
    logic [UART_ARB_WD_W-1:0] r_wd_cnt;

    // Count cycles spent in WAIT_DONE; zeroed during START.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  r_wd_cnt <= '0;
        else if (r_state == S_START) r_wd_cnt <= '0;
        else if (r_state == S_WAIT)  r_wd_cnt <= r_wd_cnt + 1'b1;
    end

    // A coincident tx_done wins over the timeout.
    assign w_timeout = (r_state == S_WAIT) && !bus.tx_done &&
                       (r_wd_cnt == UART_ARB_WD_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // Frame sequencer: IDLE -> START (one-cycle pulse) -> WAIT_DONE -> IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_tx_data <= '0;
            r_start   <= 1'b0;
            r_grant   <= '0;
            r_last    <= GW'(NUM_REQ - 1);
            r_busy    <= 1'b0;
            r_tmo     <= 1'b0;
        end else begin
            r_start <= 1'b0;
            r_tmo   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_tx_data <= w_pick_data;
                        r_grant   <= w_pick;
                        r_last    <= w_pick;
                        r_start   <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= S_START;
                    end
                end
                S_START: r_state <= S_WAIT;
                S_WAIT: begin
                    if (bus.tx_done) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_timeout) begin
                        r_busy  <= 1'b0;
                        r_tmo   <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.tx_data     = r_tx_data;
    assign bus.start_tx    = r_start;
    assign bus.grant_id    = r_grant;
    assign bus.busy        = r_busy;
    assign bus.timeout_err = r_tmo;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (NUM_REQ=4, TIMEOUT_CYCLES=64).
// Inputs change just after the falling edge; outputs are sampled 1ns later.
module tb_uart_tx_arbiter;
    localparam int N   = 4;
    localparam int TMO = 64;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(N)) bus();

    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.req_valid = '0; bus.tx_done = 1'b0; bus.cts_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.cts_n = 1'b0; bus.req_valid = '1; bus.req_data = '0; bus.tx_done = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", bus.req_ready); end
        checks++; if (bus.tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%h exp=00", bus.tx_data); end
        checks++; if (bus.grant_id !== 2'd0) begin failures++; $display("FAIL reset_grant got=%0d exp=0", bus.grant_id); end
        checks++; if ({bus.start_tx, bus.busy, bus.timeout_err} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {bus.start_tx, bus.busy, bus.timeout_err}); end
        bus.req_valid = '0;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        bit ok = 1'b1;
        @(negedge clk);
        bus.req_valid = 4'b0100; bus.req_data[2] = 8'hA5;
        #1;
        checks++; if (bus.req_ready !== 4'b0100) begin failures++; $display("FAIL single_ready got=%b exp=0100", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = '0;
        checks++; if (bus.start_tx !== 1'b1) begin failures++; $display("FAIL single_start got=%b exp=1", bus.start_tx); end
        checks++; if (bus.tx_data !== 8'hA5 || bus.grant_id !== 2'd2) begin failures++; $display("FAIL single_data got=%h/%0d exp=a5/2", bus.tx_data, bus.grant_id); end
        repeat (5) begin
            @(negedge clk);
            if (bus.start_tx !== 1'b0 || bus.tx_data !== 8'hA5 || bus.grant_id !== 2'd2 || bus.busy !== 1'b1) ok = 1'b0;
        end
        checks++; if (!ok) begin failures++; $display("FAIL single_hold got=unstable exp=stable"); end
        bus.tx_done = 1'b1;
        @(negedge clk);
        bus.tx_done = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.tx_data !== 8'hA5) begin failures++; $display("FAIL single_done busy=%b data=%h exp=0/a5", bus.busy, bus.tx_data); end
    endtask

    task automatic test_round_robin();
        logic [7:0] d [N];
        logic [N-1:0] exp_rdy;
        do_reset();
        for (int i = 0; i < N; i++) begin d[i] = 8'($urandom); bus.req_data[i] = d[i]; end
        @(negedge clk);
        bus.req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            #1;
            exp_rdy = N'(1 << (k % N));
            checks++; if (bus.req_ready !== exp_rdy || bus.start_tx !== 1'b0) begin failures++; $display("FAIL rr_ready k=%0d got=%b/%b exp=%b/0", k, bus.req_ready, bus.start_tx, exp_rdy); end
            @(negedge clk);
            checks++; if (bus.start_tx !== 1'b1 || bus.grant_id !== 2'(k % N) || bus.tx_data !== d[k % N]) begin failures++; $display("FAIL rr_start k=%0d got=%b/%0d/%h exp=1/%0d/%h", k, bus.start_tx, bus.grant_id, bus.tx_data, k % N, d[k % N]); end
            repeat (20) @(negedge clk);
            bus.tx_done = 1'b1;
            @(negedge clk);
            bus.tx_done = 1'b0;
            if (k == 4) bus.req_valid = '0;
        end
    endtask

    task automatic test_flow_control();
        bit ok = 1'b1;
        logic [7:0] d0;
        @(negedge clk);
        d0 = 8'($urandom);
        bus.cts_n = 1'b1; bus.req_valid = 4'b0001; bus.req_data[0] = d0;
        repeat (100) begin
            #1;
            if (bus.req_ready !== 4'b0000 || bus.start_tx !== 1'b0) ok = 1'b0;
            @(negedge clk);
        end
        checks++; if (!ok) begin failures++; $display("FAIL cts_hold got=activity exp=none"); end
        bus.cts_n = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL cts_fall_ready got=%b exp=0001", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = '0; bus.cts_n = 1'b1;
        checks++; if (bus.start_tx !== 1'b1 || bus.tx_data !== d0) begin failures++; $display("FAIL cts_start got=%b/%h exp=1/%h", bus.start_tx, bus.tx_data, d0); end
        repeat (4) @(negedge clk);
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL cts_inframe_busy got=%b exp=1", bus.busy); end
        bus.tx_done = 1'b1;
        @(negedge clk);
        bus.tx_done = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.timeout_err !== 1'b0) begin failures++; $display("FAIL cts_complete got=%b/%b exp=0/0", bus.busy, bus.timeout_err); end
        bus.cts_n = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.req_valid = 4'b0001; bus.req_data[0] = 8'h3C;
        @(negedge clk);
        bus.req_valid = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0; bus.req_valid = '1;
        #1;
        checks++; if (bus.req_ready !== 4'b0000 || bus.tx_data !== 8'h00 || bus.grant_id !== 2'd0) begin failures++; $display("FAIL midrst_vals got=%b/%h/%0d exp=0000/00/0", bus.req_ready, bus.tx_data, bus.grant_id); end
        checks++; if ({bus.start_tx, bus.busy, bus.timeout_err} !== 3'b000) begin failures++; $display("FAIL midrst_flags got=%b exp=000", {bus.start_tx, bus.busy, bus.timeout_err}); end
        @(negedge clk);
        rst_n = 1'b1; bus.req_valid = 4'b1010;
        #1;
        checks++; if (bus.req_ready !== 4'b0010 || bus.start_tx !== 1'b0) begin failures++; $display("FAIL midrst_first got=%b/%b exp=0010/0", bus.req_ready, bus.start_tx); end
        @(negedge clk);
        bus.req_valid = '0;
        checks++; if (bus.start_tx !== 1'b1 || bus.grant_id !== 2'd1) begin failures++; $display("FAIL midrst_grant got=%b/%0d exp=1/1", bus.start_tx, bus.grant_id); end
        repeat (2) @(negedge clk);
        bus.tx_done = 1'b1;
        @(negedge clk);
        bus.tx_done = 1'b0;
    endtask

`ifdef UART_TX_ARB_WATCHDOG_EN
    task automatic test_watchdog();
        bit ok;
        // Frame 1: no tx_done, pulse 64 cycles after entering WAIT_DONE.
        // Frame 2: tx_done lands on the timeout cycle, normal completion.
        for (int f = 0; f < 2; f++) begin
            ok = 1'b1;
            @(negedge clk);
            bus.req_valid = 4'b0001;
            for (int i = 1; i <= 70; i++) begin
                @(negedge clk);
                if (i == 1) bus.req_valid = '0;
                bus.tx_done = (f == 1 && i == 65);
                if (i == 66) begin
                    checks++; if (bus.timeout_err !== (f == 0) || bus.busy !== 1'b0) begin failures++; $display("FAIL wd_edge f=%0d got=%b/%b exp=%b/0", f, bus.timeout_err, bus.busy, f == 0); end
                end else if (bus.timeout_err !== 1'b0 || bus.busy !== (i < 66)) ok = 1'b0;
            end
            checks++; if (!ok) begin failures++; $display("FAIL wd_window f=%0d got=bad exp=clean", f); end
        end
    endtask
`else
    task automatic test_no_watchdog();
        bit ok = 1'b1;
        @(negedge clk);
        bus.req_valid = 4'b0001;
        @(negedge clk);
        bus.req_valid = '0;
        repeat (1000) begin
            @(negedge clk);
            if (bus.busy !== 1'b1 || bus.timeout_err !== 1'b0) ok = 1'b0;
        end
        checks++; if (!ok) begin failures++; $display("FAIL nowd_wait got=aborted exp=busy"); end
        bus.tx_done = 1'b1;
        @(negedge clk);
        bus.tx_done = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL nowd_done got=%b exp=0", bus.busy); end
    endtask
`endif

    // Random producers, CTS and transmitter against a frame-level model:
    // pick first pending from last+1, start one cycle after handshake,
    // free again the cycle after a tx_done that follows the start cycle.
    task automatic test_random(input int ncyc);
        int last, hs, done_at, pick, idx, mgid;
        bit free, exp_start;
        logic [7:0] mbyte;
        logic [7:0] bytes [N];
        logic [N-1:0] pend, exp_rdy;
        do_reset();
        last = N - 1; free = 1'b1; hs = -10; done_at = -1; pend = '0; mbyte = '0; mgid = 0;
        for (int i = 0; i < N; i++) bytes[i] = '0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++)
                if (!pend[i] && $urandom_range(3) == 0) begin pend[i] = 1'b1; bytes[i] = 8'($urandom); end
            bus.req_valid = pend;
            for (int i = 0; i < N; i++) bus.req_data[i] = bytes[i];
            bus.cts_n = ($urandom_range(5) == 0);
            exp_start = (hs == c - 1);
            if (c == done_at)            bus.tx_done = 1'b1;
            else if (free || exp_start)  bus.tx_done = ($urandom_range(3) == 0);
            else                         bus.tx_done = 1'b0;
            if (exp_start) done_at = c + $urandom_range(1, 8);
            #1;
            pick = -1;
            if (free && !bus.cts_n)
                for (int k = 1; k <= N; k++) begin
                    idx = (last + k) % N;
                    if (pick < 0 && pend[idx]) pick = idx;
                end
            exp_rdy = (pick >= 0) ? N'(1 << pick) : '0;
            checks++; if (bus.req_ready !== exp_rdy) begin failures++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, bus.req_ready, exp_rdy); end
            checks++; if (bus.start_tx !== exp_start || bus.busy !== !free || bus.timeout_err !== 1'b0) begin failures++; $display("FAIL rnd_flags c=%0d got=%b/%b/%b exp=%b/%b/0", c, bus.start_tx, bus.busy, bus.timeout_err, exp_start, !free); end
            if (!free) begin
                checks++; if (bus.tx_data !== mbyte || bus.grant_id !== 2'(mgid)) begin failures++; $display("FAIL rnd_data c=%0d got=%h/%0d exp=%h/%0d", c, bus.tx_data, bus.grant_id, mbyte, mgid); end
            end
            if (pick >= 0) begin
                free = 1'b0; hs = c; last = pick; mbyte = bytes[pick]; mgid = pick; pend[pick] = 1'b0;
            end else if (!free && bus.tx_done && c >= hs + 2) begin
                free = 1'b1;
            end
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_flow_control();
        test_reset_mid();
`ifdef UART_TX_ARB_WATCHDOG_EN
        test_watchdog();
`else
        test_no_watchdog();
`endif
        test_random(3000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
